// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the FIR front-end: the coefficient-loader state
// encoding and the default sizing constants for a 40-tap filter running from
// a 12 MHz clock with a 600 kHz sample rate.
// -----------------------------------------------------------------------------
package fir_pkg;

    localparam int FIR_SAMPLE_DIV = 20;
    localparam int FIR_MAX_COEFF  = 40;
    localparam int FIR_ADDR_W     = 6;
    localparam int FIR_DATA_W     = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        WRITE = 2'd2,
        CLOSE = 2'd3
    } fir_load_state_t;

endpackage

// File: rtl/fir_sample_en_gen.sv
// -----------------------------------------------------------------------------
// fir_sample_en_gen
// Modulo-DIV counter producing a one-cycle sample strobe on the terminal count.
//
// Ports
//   clk_i    : clock
//   rst_n_i  : asynchronous active-low reset
//   clr_i    : synchronous clear; holds the count at 0 and masks the strobe
//   en_o     : sample strobe, high while the count equals DIV-1
// -----------------------------------------------------------------------------
module fir_sample_en_gen
    import fir_pkg::*;
#(
    parameter int DIV = FIR_SAMPLE_DIV
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    output logic en_o
);

    localparam int              CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   TC = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_q == TC) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The clear is evaluated on the current state, so a load request landing
    // on the terminal count still lets that cycle's strobe out.
    assign en_o = (cnt_q == TC) && !clr_i;

endmodule

// File: rtl/fir_coeff_loader.sv
// -----------------------------------------------------------------------------
// fir_coeff_loader
// Front-end for the 40-tap FIR: generates the 600 kHz sample strobe and turns
// a host valid/ready coefficient stream into the filter's update protocol.
// Sample strobes are suppressed for the whole update.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | divider running, waiting for iLoadStart
//   SETUP | one cycle, update flag raised, host not yet accepted
//   WRITE | accepting host words, one per handshake, index 0..N-1
//   CLOSE | one cycle after the last word, flag still high
//
// Ports
//   iClk12M          : 12 MHz clock
//   iRsn             : asynchronous active-low reset
//   iLoadStart       : update request (honoured only in IDLE)
//   iNumOfCoeff      : tap count N, latched with iLoadStart
//   iCoeffValid      : host word valid
//   iCoeffDt         : host coefficient word
//   oCoeffReady      : loader accepts a word this cycle
//   oEnSample600k    : sample strobe
//   oCoeffUpdateFlag : high SETUP..CLOSE
//   oAddrRam         : coefficient address of the last written word
//   oWrDtRam         : coefficient data of the last written word
//   oWrPulse         : address/data carry a new word this cycle
//   oNumOfCoeff      : latched tap count
//   oLoadDone        : one-cycle pulse on return to IDLE
//   oLoadErr         : one-cycle pulse for an illegal tap count
// -----------------------------------------------------------------------------
module fir_coeff_loader
    import fir_pkg::*;
#(
    parameter int SAMPLE_DIV = FIR_SAMPLE_DIV,
    parameter int MAX_COEFF  = FIR_MAX_COEFF,
    parameter int ADDR_W     = FIR_ADDR_W,
    parameter int DATA_W     = FIR_DATA_W
) (
    input  logic              iClk12M,
    input  logic              iRsn,
    input  logic              iLoadStart,
    input  logic [ADDR_W-1:0] iNumOfCoeff,
    input  logic              iCoeffValid,
    input  logic [DATA_W-1:0] iCoeffDt,
    output logic              oCoeffReady,
    output logic              oEnSample600k,
    output logic              oCoeffUpdateFlag,
    output logic [ADDR_W-1:0] oAddrRam,
    output logic [DATA_W-1:0] oWrDtRam,
    output logic              oWrPulse,
    output logic [ADDR_W-1:0] oNumOfCoeff,
    output logic              oLoadDone,
    output logic              oLoadErr
);

    fir_load_state_t   state_q, state_d;
    logic [ADDR_W-1:0] num_q,   num_d;
    logic [ADDR_W-1:0] idx_q,   idx_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic              wr_q,    wr_d;
    logic              done_q,  done_d;
    logic              err_q,   err_d;

    logic              count_legal;
    logic              last_word;
    logic              busy;

    assign count_legal = (iNumOfCoeff != '0) &&
                         (iNumOfCoeff <= ADDR_W'(MAX_COEFF));
    assign last_word   = (idx_q == num_q - ADDR_W'(1));
    assign busy        = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_d    = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (iLoadStart) begin
                    if (count_legal) begin
                        num_d   = iNumOfCoeff;
                        idx_d   = '0;
                        state_d = SETUP;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SETUP: begin
                state_d = WRITE;
            end
            WRITE: begin
                // oCoeffReady is high for the whole of WRITE, so valid alone
                // completes the handshake.
                if (iCoeffValid) begin
                    addr_d = idx_q;
                    data_d = iCoeffDt;
                    wr_d   = 1'b1;
                    if (last_word) begin
                        state_d = CLOSE;
                    end else begin
                        idx_d = idx_q + ADDR_W'(1);
                    end
                end
            end
            CLOSE: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            state_q <= IDLE;
            num_q   <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    fir_sample_en_gen #(
        .DIV (SAMPLE_DIV)
    ) u_sample_en (
        .clk_i   (iClk12M),
        .rst_n_i (iRsn),
        .clr_i   (busy),
        .en_o    (oEnSample600k)
    );

    assign oCoeffReady      = (state_q == WRITE);
    assign oCoeffUpdateFlag = busy;
    assign oAddrRam         = addr_q;
    assign oWrDtRam         = data_q;
    assign oWrPulse         = wr_q;
    assign oNumOfCoeff      = num_q;
    assign oLoadDone        = done_q;
    assign oLoadErr         = err_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// -----------------------------------------------------------------------------
// tb_fir_coeff_loader
// Directed bench for fir_coeff_loader. Inputs change and outputs are sampled
// on the falling edge; "rel" counts falling edges after the load request was
// presented, so rel=1 is the first cycle after the edge that sampled it.
// -----------------------------------------------------------------------------
module tb_fir_coeff_loader;

    logic        clk = 1'b0;
    logic        iRsn;
    logic        iLoadStart;
    logic [5:0]  iNumOfCoeff;
    logic        iCoeffValid;
    logic [15:0] iCoeffDt;
    logic        oCoeffReady;
    logic        oEnSample600k;
    logic        oCoeffUpdateFlag;
    logic [5:0]  oAddrRam;
    logic [15:0] oWrDtRam;
    logic        oWrPulse;
    logic [5:0]  oNumOfCoeff;
    logic        oLoadDone;
    logic        oLoadErr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fir_coeff_loader dut (
        .iClk12M          (clk),
        .iRsn             (iRsn),
        .iLoadStart       (iLoadStart),
        .iNumOfCoeff      (iNumOfCoeff),
        .iCoeffValid      (iCoeffValid),
        .iCoeffDt         (iCoeffDt),
        .oCoeffReady      (oCoeffReady),
        .oEnSample600k    (oEnSample600k),
        .oCoeffUpdateFlag (oCoeffUpdateFlag),
        .oAddrRam         (oAddrRam),
        .oWrDtRam         (oWrDtRam),
        .oWrPulse         (oWrPulse),
        .oNumOfCoeff      (oNumOfCoeff),
        .oLoadDone        (oLoadDone),
        .oLoadErr         (oLoadErr)
    );

    // results of the last run_load
    logic [5:0]  wr_addr [0:63];
    logic [15:0] wr_data [0:63];
    int nw, flag_first, ready_first, flag_cycles, strobes_in_load;
    int done_cnt, done_rel, last_wr_rel, err_cnt, hold_bad;
    int post_wr, post_ready, first_strobe;
    bit timed_out;

    function automatic logic [15:0] coeff_word(input int i);
        logic [15:0] v;
        v = 16'(i) * 16'h0457;
        return v ^ 16'hC35A;
    endfunction

    function automatic logic [38:0] all_outs();
        return {oCoeffReady, oEnSample600k, oCoeffUpdateFlag, oAddrRam, oWrDtRam,
                oWrPulse, oNumOfCoeff, oLoadDone, oLoadErr};
    endfunction

    // Host model: issues the request, feeds words, records what the DUT writes.
    task automatic run_load(input logic [5:0] n, input bit toggle,
                            input int restart_rel, input int abort_wr);
        int rel;
        int host_idx;
        bit phase;
        bit stop;
        logic [5:0] prev_addr;
        nw = 0; flag_first = -1; ready_first = -1; flag_cycles = 0;
        strobes_in_load = 0; done_cnt = 0; done_rel = -1; last_wr_rel = -1;
        err_cnt = 0; hold_bad = 0; post_wr = 0; post_ready = 0;
        first_strobe = -1; timed_out = 0;
        host_idx = 0; phase = 0; stop = 0; rel = 0;
        prev_addr = oAddrRam;
        iLoadStart  = 1'b1;
        iNumOfCoeff = n;
        iCoeffValid = 1'b0;
        iCoeffDt    = coeff_word(0);
        while (!stop) begin
            @(negedge clk);
            rel++;
            iLoadStart = 1'b0;
            if (oCoeffUpdateFlag) begin
                flag_cycles++;
                if (flag_first < 0) flag_first = rel;
            end
            if (oCoeffReady && ready_first < 0) ready_first = rel;
            if (oEnSample600k) strobes_in_load++;
            if (oLoadErr) err_cnt++;
            if (oWrPulse) begin
                if (nw < 64) begin
                    wr_addr[nw] = oAddrRam;
                    wr_data[nw] = oWrDtRam;
                end
                nw++;
                last_wr_rel = rel;
            end else if (oAddrRam !== prev_addr) begin
                hold_bad++;
            end
            prev_addr = oAddrRam;
            if (oLoadDone) begin
                done_cnt++;
                done_rel = rel;
                stop = 1;
            end
            if (abort_wr > 0 && nw == abort_wr) stop = 1;
            if (!stop && rel >= 200) begin
                timed_out = 1;
                stop = 1;
            end
            if (!stop) begin
                if (rel == restart_rel) begin
                    iLoadStart  = 1'b1;
                    iNumOfCoeff = 6'd2;
                end
                phase = ~phase;
                iCoeffValid = toggle ? phase : 1'b1;
                iCoeffDt = coeff_word(host_idx);
                if (oCoeffReady && iCoeffValid) host_idx++;
            end
        end
        if (done_rel > 0) begin
            // keep offering an extra word after the load has closed
            iCoeffValid = 1'b1;
            iCoeffDt    = 16'hDEAD;
            for (int j = 1; j <= 25; j++) begin
                @(negedge clk);
                if (oWrPulse) post_wr++;
                if (oCoeffReady) post_ready++;
                if (oEnSample600k && first_strobe < 0) first_strobe = j;
            end
            iCoeffValid = 1'b0;
        end
    endtask

    task automatic wait_strobe(output bit ok);
        ok = 0;
        for (int i = 0; i < 25 && !ok; i++) begin
            @(negedge clk);
            if (oEnSample600k) ok = 1;
        end
    endtask

    task automatic check_words(input string tag, input int n);
        for (int i = 0; i < n && i < 64; i++) begin
            n_checks++;
            if (wr_addr[i] !== 6'(i) || wr_data[i] !== coeff_word(i)) begin
                n_fail++;
                $display("FAIL %s word %0d: got addr %0d data %h, expected addr %0d data %h",
                         tag, i, wr_addr[i], wr_data[i], i, coeff_word(i));
            end
        end
    endtask

    task automatic test_reset();
        iRsn = 1'b0; iLoadStart = 1'b0; iNumOfCoeff = '0;
        iCoeffValid = 1'b0; iCoeffDt = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (all_outs() !== 39'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", all_outs());
        end
        iRsn = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (i > 0) @(negedge clk);
            n_checks++;
            if (oEnSample600k !== ((i % 20) == 19)) begin
                n_fail++;
                $display("FAIL idle_strobe cycle %0d: got %b expected %b",
                         i, oEnSample600k, ((i % 20) == 19));
            end
            n_checks++;
            if ({oCoeffReady, oCoeffUpdateFlag, oAddrRam, oWrDtRam, oWrPulse,
                 oNumOfCoeff, oLoadDone, oLoadErr} !== 38'd0) begin
                n_fail++;
                $display("FAIL idle_quiet cycle %0d: outputs not all zero", i);
            end
        end
    endtask

    task automatic test_load40();
        bit ok;
        wait_strobe(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL load40_sync: strobe seen 0 expected 1"); end
        // request presented in the terminal-count cycle
        run_load(6'd40, 0, -1, 0);
        n_checks++;
        if (timed_out) begin n_fail++; $display("FAIL load40_timeout: done seen 0 expected 1"); end
        n_checks++;
        if (flag_first !== 1 || ready_first !== 2) begin
            n_fail++;
            $display("FAIL load40_start: flag at %0d ready at %0d, expected 1 and 2",
                     flag_first, ready_first);
        end
        n_checks++;
        if (nw !== 40 || last_wr_rel !== 42) begin
            n_fail++;
            $display("FAIL load40_writes: got %0d ending rel %0d, expected 40 ending 42",
                     nw, last_wr_rel);
        end
        check_words("load40", 40);
        n_checks++;
        if (flag_cycles !== 42 || done_rel !== 43 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL load40_flag: flag %0d cycles done at %0d x%0d, expected 42, 43, x1",
                     flag_cycles, done_rel, done_cnt);
        end
        n_checks++;
        if (strobes_in_load !== 0) begin
            n_fail++;
            $display("FAIL load40_no_strobe: got %0d strobes expected 0", strobes_in_load);
        end
        n_checks++;
        if (first_strobe !== 19) begin
            n_fail++;
            $display("FAIL load40_first_strobe: got %0d cycles after done, expected 19", first_strobe);
        end
        n_checks++;
        if (oNumOfCoeff !== 6'd40 || err_cnt !== 0) begin
            n_fail++;
            $display("FAIL load40_num: got N %0d err %0d expected 40 and 0", oNumOfCoeff, err_cnt);
        end
    endtask

    task automatic test_toggle4();
        run_load(6'd4, 1, -1, 0);
        n_checks++;
        if (timed_out || nw !== 4 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL toggle4_writes: got %0d writes done %0d, expected 4 and 1", nw, done_cnt);
        end
        check_words("toggle4", 4);
        n_checks++;
        if (hold_bad !== 0) begin
            n_fail++;
            $display("FAIL toggle4_addr_hold: got %0d changes without write, expected 0", hold_bad);
        end
        n_checks++;
        if (post_wr !== 0 || post_ready !== 0) begin
            n_fail++;
            $display("FAIL toggle4_extra_word: got wr %0d ready %0d expected 0 and 0",
                     post_wr, post_ready);
        end
        n_checks++;
        if (oNumOfCoeff !== 6'd4 || oAddrRam !== 6'd3 || oWrDtRam !== coeff_word(3)) begin
            n_fail++;
            $display("FAIL toggle4_final: got N %0d addr %0d data %h expected 4, 3, %h",
                     oNumOfCoeff, oAddrRam, oWrDtRam, coeff_word(3));
        end
    endtask

    task automatic test_illegal(input logic [5:0] n);
        bit ok;
        int errs;
        int gap;
        wait_strobe(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL illegal_sync N=%0d: strobe seen 0 expected 1", n); end
        iLoadStart = 1'b1;
        iNumOfCoeff = n;
        errs = 0;
        gap = -1;
        for (int d = 1; d <= 25 && gap < 0; d++) begin
            @(negedge clk);
            iLoadStart = 1'b0;
            if (oLoadErr) errs++;
            if (d == 1) begin
                n_checks++;
                if (oLoadErr !== 1'b1 || oCoeffUpdateFlag !== 1'b0 ||
                    oCoeffReady !== 1'b0 || oNumOfCoeff !== 6'd4) begin
                    n_fail++;
                    $display("FAIL illegal_pulse N=%0d: got err %b flag %b ready %b num %0d expected 1 0 0 4",
                             n, oLoadErr, oCoeffUpdateFlag, oCoeffReady, oNumOfCoeff);
                end
            end
            if (oEnSample600k) gap = d;
        end
        n_checks++;
        if (errs !== 1 || gap !== 20) begin
            n_fail++;
            $display("FAIL illegal_divider N=%0d: got %0d errs strobe gap %0d expected 1 and 20",
                     n, errs, gap);
        end
    endtask

    task automatic test_ignore_restart();
        run_load(6'd5, 0, 3, 0);
        n_checks++;
        if (timed_out || nw !== 5 || done_cnt !== 1 || err_cnt !== 0 || oNumOfCoeff !== 6'd5) begin
            n_fail++;
            $display("FAIL ignore_restart: got %0d writes done %0d err %0d N %0d expected 5 1 0 5",
                     nw, done_cnt, err_cnt, oNumOfCoeff);
        end
        check_words("ignore_restart", 5);
    endtask

    task automatic test_reset_mid();
        run_load(6'd10, 0, -1, 3);
        n_checks++;
        if (nw !== 3 || oCoeffUpdateFlag !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_before_reset: got %0d writes flag %b expected 3 and 1",
                     nw, oCoeffUpdateFlag);
        end
        iRsn = 1'b0;
        #1;
        n_checks++;
        if (all_outs() !== 39'd0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got %h expected 0", all_outs());
        end
        iCoeffValid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        iRsn = 1'b1;
        run_load(6'd10, 0, -1, 0);
        n_checks++;
        if (timed_out || nw !== 10 || done_cnt !== 1 || oNumOfCoeff !== 6'd10) begin
            n_fail++;
            $display("FAIL mid_reload: got %0d writes done %0d N %0d expected 10 1 10",
                     nw, done_cnt, oNumOfCoeff);
        end
        check_words("mid_reload", 10);
    endtask

    initial begin
        test_reset();
        test_load40();
        test_toggle4();
        test_illegal(6'd0);
        test_illegal(6'd41);
        test_ignore_restart();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
